// File: rtl/alu_exec_pkg.sv
// Shared types and default sizes for the alu_exec slice.
package alu_exec_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int AW_DEF    = 4;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_SLL  = 3'b101,
      OP_SRL  = 3'b110,
      OP_PASS = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RDA,
      S_RDB,
      S_EXEC,
      S_DONE
   } state_e;

endpackage

// File: rtl/alu_exec_core.sv
// Combinational operation logic: y = op(a, b). Shifts use b[4:0] as the amount.
module alu_core
   import alu_exec_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   logic [4:0] sh;
   assign sh = b[4:0];

   always_comb begin
      y = '0;
      case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_SLL:  y = a << sh;
         OP_SRL:  y = a >> sh;
         OP_PASS: y = a;
         default: y = a;
      endcase
   end

endmodule

// File: rtl/alu_exec.sv
// Command sequencer: reads two operands from an external registered file, executes, holds result.
// Optional macro ALU_EXEC_SAME_SRC_EN skips the second read when ra == rb.
//
// state  | meaning
// IDLE   | ready for a command
// RDA    | read select = ra
// RDB    | read select = rb, operand A arrives
// EXEC   | operand B arrives, result registered
// DONE   | result offered until res_ready
module alu_exec
   import alu_exec_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [AW-1:0]    cmd_ra,
   input  logic [AW-1:0]    cmd_rb,
   input  logic [AW-1:0]    cmd_rd,
   output logic [AW-1:0]    rf_so,
   output logic             rf_en,
   input  logic [WIDTH-1:0] rf_do,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [AW-1:0]    res_rd,
   output logic             res_zero
);

   state_e           state, state_nxt;
   op_e              op_q;
   logic [AW-1:0]    ra_q, rb_q, rd_q;
   logic [WIDTH-1:0] a_q, a_op, y;

`ifdef ALU_EXEC_SAME_SRC_EN
   // With a shared source, RDB is skipped and the single read feeds both operands.
   assign a_op = (ra_q == rb_q) ? rf_do : a_q;
`else
   assign a_op = a_q;
`endif

   alu_core #(.WIDTH(WIDTH)) u_core (
      .op (op_q),
      .a  (a_op),
      .b  (rf_do),
      .y  (y)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rf_en     = 1'b0;
      rf_so     = '0;
      res_valid = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = S_RDA;
         end
         S_RDA: begin
            rf_en = 1'b1;
            rf_so = ra_q;
`ifdef ALU_EXEC_SAME_SRC_EN
            state_nxt = (ra_q == rb_q) ? S_EXEC : S_RDB;
`else
            state_nxt = S_RDB;
`endif
         end
         S_RDB: begin
            rf_en     = 1'b1;
            rf_so     = rb_q;
            state_nxt = S_EXEC;
         end
         S_EXEC: state_nxt = S_DONE;
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q     <= OP_ADD;
         ra_q     <= '0;
         rb_q     <= '0;
         rd_q     <= '0;
         a_q      <= '0;
         res_data <= '0;
         res_rd   <= '0;
         res_zero <= 1'b0;
      end else begin
         if (state == S_IDLE && cmd_valid) begin
            op_q <= op_e'(cmd_op);
            ra_q <= cmd_ra;
            rb_q <= cmd_rb;
            rd_q <= cmd_rd;
         end
         if (state == S_RDB) a_q <= rf_do;
         if (state == S_EXEC) begin
            res_data <= y;
            res_rd   <= rd_q;
            res_zero <= (y == '0);
         end
      end
   end

endmodule
